// File: rtl/jk_cnt_pkg.sv
// jk_cnt_pkg: JK command encodings ({J,K}) and default counter geometry
package jk_cnt_pkg;
  typedef logic [1:0] jk_cmd_t;
  localparam jk_cmd_t JK_HOLD   = 2'b00;
  localparam jk_cmd_t JK_RESET  = 2'b01;
  localparam jk_cmd_t JK_SET    = 2'b10;
  localparam jk_cmd_t JK_TOGGLE = 2'b11;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 10;
endpackage

// File: rtl/jk_stage_ff.sv
// jk_stage_ff: JK flip-flop with asynchronous active-low reset and complementary outputs
module jk_stage_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);
  logic r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= (j & ~r_q) | (~k & r_q);
  assign q  = r_q;
  assign qn = ~r_q;
endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: mod-MODULUS up/down counter of JK stages; JK_SYNC_COUNTER_SATURATE_EN holds at the boundaries instead of wrapping
module jk_sync_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrap
);
`ifdef JK_SYNC_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] w_load_v;
  logic [WIDTH-1:0] w_wrap_v;
  logic [WIDTH-1:0] w_step;
  jk_cmd_t          w_cmd [WIDTH];
  logic             r_wrap;
  always_comb begin
    w_load_v = ({1'b0, load_val} >= MOD_W) ? MAX_V : load_val;
    w_wrap_v = up ? '0 : MAX_V;
    w_step   = count ^ (up ? count + 1'b1 : count - 1'b1);
    tc       = en & ~load & (up ? (count == MAX_V) : (count == '0));
  end
  // loads and wraps force each bit to its target; ordinary steps toggle only the bits that change
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_cmd[i] = load ? (w_load_v[i] ? JK_SET : JK_RESET)
                    : tc   ? (SAT ? JK_HOLD : (w_wrap_v[i] ? JK_SET : JK_RESET))
                    : en   ? (w_step[i] ? JK_TOGGLE : JK_HOLD)
                    : JK_HOLD;
    jk_stage_ff u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (w_cmd[i][1]),
      .k    (w_cmd[i][0]),
      .q    (count[i]),
      .qn   (count_n[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wrap <= 1'b0;
    else        r_wrap <= ~SAT & tc;
  assign wrap = r_wrap;
endmodule

// File: tb/tb_jk_sync_counter.sv
// tb_jk_sync_counter: table-driven check of jk_sync_counter (WIDTH=4, MODULUS=10) plus reset/saturation sequences
module tb_jk_sync_counter;
`ifdef JK_SYNC_COUNTER_SATURATE_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count;
  logic [3:0] count_n;
  logic       tc;
  logic       wrap;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic       ld;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic       tc;
    logic [3:0] cnt;
    logic       wr;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .count_n (count_n),
    .tc      (tc),
    .wrap    (wrap)
  );
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic add(input logic ld, input logic e, input logic u, input logic [3:0] lv,
                     input logic etc, input logic [3:0] ec, input logic ew);
    vq.push_back('{ld, e, u, lv, etc, ec, ew});
  endtask
  task automatic run(input vec_t x, input int idx);
    logic [3:0] exp_n;
    exp_n = ~x.cnt;
    @(negedge clk);
    load = x.ld; en = x.en; up = x.up; load_val = x.lv;
    #1 chk($sformatf("tc[%0d]", idx), int'(tc), int'(x.tc));
    @(posedge clk);
    #1;
    chk($sformatf("count[%0d]", idx), int'(count), int'(x.cnt));
    chk($sformatf("count_n[%0d]", idx), int'(count_n), int'(exp_n));
    chk($sformatf("wrap[%0d]", idx), int'(wrap), int'(x.wr));
  endtask
  initial begin
    for (int k = 0; k < 9; k++) add(0, 1, 1, 0, 0, 4'(k + 1), 0);
    add(0, 1, 1, 0, 1, S ? 4'd9 : 4'd0, !S);
    add(1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, S ? 4'd0 : 4'd9, !S);
    add(1, 1, 1, 3, 0, 3, 0);
    add(1, 1, 1, 6, 0, 6, 0);
    add(1, 1, 1, 13, 0, 9, 0);
    add(1, 1, 1, 15, 0, 9, 0);
    add(1, 1, 1, 10, 0, 9, 0);
    add(0, 0, 1, 0, 0, 9, 0);
    add(1, 0, 0, 7, 0, 7, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 1'(k), 4'(k), 0, 7, 0);
    add(1, 0, 0, 5, 0, 5, 0);
    add(0, 1, 1, 0, 0, 6, 0);
    add(0, 1, 0, 0, 0, 5, 0);
    add(0, 1, 1, 0, 0, 6, 0);
    add(0, 1, 0, 0, 0, 5, 0);
    add(1, 1, 1, 2, 0, 2, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, S ? 4'd0 : 4'd9, !S);
    add(1, 1, 1, 9, 0, 9, 0);
    #2;
    chk("reset count", int'(count), 0);
    chk("reset count_n", int'(count_n), 15);
    chk("reset wrap", int'(wrap), 0);
    @(negedge clk);
    chk("reset held over edge", int'(count), 0);
    rst_n = 1'b1;
    foreach (vq[i]) run(vq[i], i);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      load = 1'b0; en = 1'b1; up = 1'b1;
      #1 chk($sformatf("sat tc[%0d]", k), int'(tc), S ? 1 : int'(k == 0));
      @(posedge clk);
      #1;
      chk($sformatf("sat count[%0d]", k), int'(count), S ? 9 : k);
      chk($sformatf("sat wrap[%0d]", k), int'(wrap), int'(!S && k == 0));
    end
    @(negedge clk);
    load = 1'b1; load_val = 4'd7;
    @(posedge clk);
    #1 chk("load 7", int'(count), 7);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset count", int'(count), 0);
    chk("async reset count_n", int'(count_n), 15);
    chk("async reset wrap", int'(wrap), 0);
    load = 1'b1; load_val = 4'd4;
    @(posedge clk);
    #1 chk("load during reset", int'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("first edge after reset", int'(count), 4);
    chk("wrap after reset", int'(wrap), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter bit width (2..16).
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 count  output  WIDTH  current count (JK stage Q outputs).
REQ-010 count_n  output  WIDTH  bitwise complement of count (JK stage Qn outputs).
REQ-011 tc  output  1  combinational terminal count.
REQ-012 wrap  output  1  registered one-cycle pulse following a wrap.

Function
REQ-013 Each count bit SHALL be held in its own JK stage; next state SHALL be produced only by driving that stage's J/K inputs.
REQ-014 Priority SHALL be load > en > hold.
REQ-015 load=1: count SHALL become load_val on the next edge (J=load_val[i], K=~load_val[i]); load_val >= MODULUS SHALL load MODULUS-1.
REQ-016 load=0, en=1, up=1: count SHALL increment by 1; at MODULUS-1 it SHALL wrap to 0.
REQ-017 load=0, en=1, up=0: count SHALL decrement by 1; at 0 it SHALL wrap to MODULUS-1.
REQ-018 Counting SHALL use toggle encoding: J=K=1 on bits that change, J=K=0 on bits that hold; wrap SHALL use set/reset encoding to reach the target value.
REQ-019 load=0, en=0: all stages SHALL be driven J=K=0; count SHALL hold.
REQ-020 tc SHALL equal en & ~load & ((up & count==MODULUS-1) | (~up & count==0)).
REQ-021 wrap SHALL be 1 for exactly one cycle, in the cycle after an edge on which tc was 1, otherwise 0.
REQ-022 Changing up while en=1 SHALL take effect on the same edge with no dead cycle.
REQ-023 Latency from any input to count SHALL be one clock edge; count_n SHALL equal ~count at all times.

Reset
REQ-024 rst_n=0 SHALL immediately force count=0, count_n=all ones, wrap=0, independent of clk.
REQ-025 Reset asserted mid-count or mid-load SHALL discard the operation; the first edge after deassertion SHALL act on inputs present at that edge.

Configuration
REQ-026 Macro JK_SYNC_COUNTER_SATURATE_EN defined: at a boundary with tc=1, count SHALL hold (J=K=0), and wrap SHALL never assert; tc SHALL behave unchanged.
REQ-027 Macro JK_SYNC_COUNTER_SATURATE_EN undefined: wrap-around per REQ-016/017/021.

Structure
REQ-028 Package jk_cnt_pkg SHALL hold JK command constants (JK_HOLD=00, JK_RESET=01, JK_SET=10, JK_TOGGLE=11 as {J,K}) and the default WIDTH/MODULUS values.
REQ-029 One sub-module, jk_stage_ff (JK flip-flop with asynchronous active-low reset, q and qn outputs), SHALL be instantiated WIDTH times; the next-state/J-K decode SHALL reside in jk_sync_counter.

Verification (WIDTH=4, MODULUS=10)
REQ-030 Reset: rst_n=0 between edges with count=7 -> count=0, count_n=4'hF, wrap=0 immediately.
REQ-031 Up count: en=1, up=1 from 0 for 10 edges -> 1..9,0; tc=1 only while count=9; wrap=1 the single cycle after 9->0.
REQ-032 Down wrap: count=0, en=1, up=0 -> tc=1, next count=9, wrap pulses once.
REQ-033 Load priority: count=3, en=1, load=1, load_val=6 -> count=6; load_val=13 -> count=9; tc=0 while load=1.
REQ-034 Hold/direction: en=0 for 5 edges -> count unchanged; toggle up each edge with en=1 from 5 -> 6,5,6,5.
REQ-035 Saturate build: macro defined, count=9, en=1, up=1 for 3 edges -> count stays 9, tc=1, wrap never 1.
